// File: rtl/hr_pkg.sv
// rtl/hr_pkg.sv - shared verdict codes, FSM states and arithmetic helpers for the RR analyzer
package hr_pkg;

  localparam logic [2:0] V_NORMAL   = 3'd0;
  localparam logic [2:0] V_BRADY    = 3'd1;
  localparam logic [2:0] V_TACHY    = 3'd2;
  localparam logic [2:0] V_IRREG    = 3'd3;
  localparam logic [2:0] V_ASYSTOLE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_ASYST
  } hr_state_e;

  // Unsigned distance, always larger minus smaller so it never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler that can be realigned to an accepted beat
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // tick is independent of restart so the beat logic can fold the coincident tick into its sample.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (restart || (cnt_q == LAST)) cnt_d = '0;
      else                            cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rr_interval_analyzer.sv
// rtl/rr_interval_analyzer.sv - beat-to-beat interval measurement, live rhythm flags and windowed verdict
module rr_interval_analyzer #(
  parameter int TICK_DIV    = 50000,
  parameter int INTERVAL_W  = 16,
  parameter int BRADY_MS    = 1000,
  parameter int TACHY_MS    = 600,
  parameter int IRREG_MS    = 120,
  parameter int REFRACT_MS  = 200,
  parameter int TIMEOUT_MS  = 2000,
  parameter int WINDOW      = 8,
  parameter int IRREG_LIMIT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          beat_in,
  output logic [INTERVAL_W-1:0]         interval_ms,
  output logic                          interval_valid,
  output logic                          brady,
  output logic                          tachy,
  output logic                          irregular,
  output logic                          asystole,
  output logic                          summary_valid,
  output logic [INTERVAL_W-1:0]         avg_ms,
  output logic [$clog2(WINDOW+1)-1:0]   irr_count,
  output logic [2:0]                    verdict
);

  import hr_pkg::*;

  localparam int LOGW  = $clog2(WINDOW);
  localparam int SUM_W = INTERVAL_W + LOGW;
  localparam int CNT_W = $clog2(WINDOW + 1);

  localparam logic [INTERVAL_W-1:0] MS_MAX    = '1;
  localparam logic [INTERVAL_W-1:0] REFRACT_T = INTERVAL_W'(REFRACT_MS);
  localparam logic [INTERVAL_W-1:0] TIMEOUT_T = INTERVAL_W'(TIMEOUT_MS);
  localparam logic [INTERVAL_W-1:0] BRADY_T   = INTERVAL_W'(BRADY_MS);
  localparam logic [INTERVAL_W-1:0] TACHY_T   = INTERVAL_W'(TACHY_MS);
  localparam logic [31:0]           IRREG_T   = 32'(IRREG_MS);
  localparam logic [CNT_W-1:0]      WIN_FULL  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0]      IRR_LIM   = CNT_W'(IRREG_LIMIT);

  logic sync1_q, sync2_q, sync3_q, beat_q;

  hr_state_e             state_q;
  logic [INTERVAL_W-1:0] ms_cnt_q;
  logic [INTERVAL_W-1:0] prev_q;
  logic                  prev_valid_q;
  logic [SUM_W-1:0]      sum_q;
  logic [CNT_W-1:0]      n_q;
  logic [CNT_W-1:0]      irr_cnt_q;

  logic [INTERVAL_W-1:0] interval_q;
  logic                  iv_q, brady_q, tachy_q, irr_q, asys_q, sv_q;
  logic [INTERVAL_W-1:0] avg_q;
  logic [CNT_W-1:0]      irr_count_q;
  logic [2:0]            verdict_q;

  logic                  tick;
  logic [INTERVAL_W-1:0] ms_now;
  logic                  beat_evt, in_measure, accept, emit, timeout, irr_now, win_full;
  logic [SUM_W-1:0]      sum_base, sum_shift;
  logic [CNT_W-1:0]      n_base, irr_base;
  logic [INTERVAL_W-1:0] avg_now;
  logic [2:0]            verdict_now;

  // The synchroniser keeps shifting while disabled so a stale level never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      sync1_q <= beat_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      beat_q  <= en && sync2_q && !sync3_q;
    end
  end

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .restart(accept),
    .tick   (tick)
  );

  // ms_now counts the tick landing on this very edge, so a beat spaced N ms apart reads N.
  assign ms_now     = (ms_cnt_q == MS_MAX) ? MS_MAX : ms_cnt_q + INTERVAL_W'(tick);
  assign beat_evt   = beat_q && en;
  assign in_measure = (state_q == ST_MEASURE);
  assign accept     = beat_evt && (!in_measure || (ms_now >= REFRACT_T));
  assign emit       = accept && in_measure;
  assign timeout    = en && in_measure && !accept && (ms_now >= TIMEOUT_T);
  assign irr_now    = prev_valid_q && (abs_diff(32'(ms_now), 32'(prev_q)) > IRREG_T);

  assign win_full   = (n_q == WIN_FULL);
  assign sum_base   = win_full ? '0 : sum_q;
  assign n_base     = win_full ? '0 : n_q;
  assign irr_base   = win_full ? '0 : irr_cnt_q;
  assign sum_shift  = sum_q >> LOGW;
  assign avg_now    = sum_shift[INTERVAL_W-1:0];

  always_comb begin
    verdict_now = V_NORMAL;
    if (irr_cnt_q >= IRR_LIM)   verdict_now = V_IRREG;
    else if (avg_now < TACHY_T) verdict_now = V_TACHY;
    else if (avg_now > BRADY_T) verdict_now = V_BRADY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ms_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      sum_q        <= '0;
      n_q          <= '0;
      irr_cnt_q    <= '0;
      interval_q   <= '0;
      iv_q         <= 1'b0;
      brady_q      <= 1'b0;
      tachy_q      <= 1'b0;
      irr_q        <= 1'b0;
      asys_q       <= 1'b0;
      sv_q         <= 1'b0;
      avg_q        <= '0;
      irr_count_q  <= '0;
      verdict_q    <= V_NORMAL;
    end else begin
      iv_q <= 1'b0;
      sv_q <= 1'b0;
      if (en) begin
        ms_cnt_q <= accept ? '0 : ms_now;

        if (win_full) begin
          sv_q        <= 1'b1;
          avg_q       <= avg_now;
          irr_count_q <= irr_cnt_q;
          verdict_q   <= verdict_now;
          sum_q       <= '0;
          n_q         <= '0;
          irr_cnt_q   <= '0;
        end

        case (state_q)
          ST_IDLE: begin
            if (accept) state_q <= ST_MEASURE;
          end
          ST_MEASURE: begin
            if (emit) begin
              interval_q   <= ms_now;
              iv_q         <= 1'b1;
              brady_q      <= (ms_now > BRADY_T);
              tachy_q      <= (ms_now < TACHY_T);
              irr_q        <= irr_now;
              prev_q       <= ms_now;
              prev_valid_q <= 1'b1;
              sum_q        <= sum_base + SUM_W'(ms_now);
              n_q          <= n_base + CNT_W'(1);
              irr_cnt_q    <= irr_base + CNT_W'(irr_now);
            end else if (timeout) begin
              state_q      <= ST_ASYST;
              asys_q       <= 1'b1;
              prev_valid_q <= 1'b0;
              if (n_base != '0) begin
                sv_q        <= 1'b1;
                verdict_q   <= V_ASYSTOLE;
                avg_q       <= '0;
                irr_count_q <= irr_base;
              end
              sum_q     <= '0;
              n_q       <= '0;
              irr_cnt_q <= '0;
            end
          end
          ST_ASYST: begin
            if (accept) begin
              state_q <= ST_MEASURE;
              asys_q  <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign interval_ms    = interval_q;
  assign interval_valid = iv_q && en;
  assign brady          = brady_q;
  assign tachy          = tachy_q;
  assign irregular      = irr_q;
  assign asystole       = asys_q;
  assign summary_valid  = sv_q && en;
  assign avg_ms         = avg_q;
  assign irr_count      = irr_count_q;
  assign verdict        = verdict_q;

endmodule

// File: tb/tb_rr_interval_analyzer.sv
// tb/tb_rr_interval_analyzer.sv - directed self-checking bench for rr_interval_analyzer
module tb_rr_interval_analyzer;

  localparam int TD = 2;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          beat_in = 1'b0;
  logic [IW-1:0] interval_ms;
  logic          interval_valid, brady, tachy, irregular, asystole, summary_valid;
  logic [IW-1:0] avg_ms;
  logic [3:0]    irr_count;
  logic [2:0]    verdict;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int last_rise = 0;
  int asys_rise = -1;
  logic asys_prev = 1'b0;

  int         iv_ms[$];
  logic [2:0] iv_fl[$];
  int         sm_avg[$];
  int         sm_irr[$];
  int         sm_ver[$];

  rr_interval_analyzer #(
    .TICK_DIV(TD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .beat_in       (beat_in),
    .interval_ms   (interval_ms),
    .interval_valid(interval_valid),
    .brady         (brady),
    .tachy         (tachy),
    .irregular     (irregular),
    .asystole      (asystole),
    .summary_valid (summary_valid),
    .avg_ms        (avg_ms),
    .irr_count     (irr_count),
    .verdict       (verdict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (interval_valid === 1'b1) begin
      iv_ms.push_back(int'(interval_ms));
      iv_fl.push_back({brady, tachy, irregular});
    end
    if (summary_valid === 1'b1) begin
      sm_avg.push_back(int'(avg_ms));
      sm_irr.push_back(int'(irr_count));
      sm_ver.push_back(int'(verdict));
    end
    if (asystole === 1'b1 && asys_prev !== 1'b1) asys_rise = cyc;
    asys_prev = asystole;
  end

  task automatic clear_logs();
    iv_ms.delete();
    iv_fl.delete();
    sm_avg.delete();
    sm_irr.delete();
    sm_ver.delete();
    asys_rise = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic beat_then_wait(input int ms);
    last_rise = cyc;
    beat_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 beat_in = 1'b0;
    repeat (ms * TD - 4) @(posedge clk);
    #1;
  endtask

  task automatic wait_ms(input int ms);
    repeat (ms * TD) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    beat_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (interval_ms !== '0) $display("FAIL reset_interval got %0d want 0", interval_ms); else pass_cnt++;
    total_cnt++; if ({interval_valid, brady, tachy, irregular, asystole, summary_valid} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {interval_valid, brady, tachy, irregular, asystole, summary_valid}); else pass_cnt++;
    total_cnt++; if ({avg_ms, irr_count, verdict} !== '0)
      $display("FAIL reset_summary got avg=%0d irr=%0d verdict=%0d want 0", avg_ms, irr_count, verdict); else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_steady();
    clear_logs();
    for (int i = 0; i < 8; i++) beat_then_wait(800);
    beat_then_wait(20);
    total_cnt++; if (iv_ms.size() != 8) $display("FAIL steady_count got %0d want 8", iv_ms.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= iv_ms.size() || iv_ms[i] != 800 || iv_fl[i] !== 3'b000)
        $display("FAIL steady_interval[%0d] got %0d flags %b want 800 flags 000", i,
                 (i < iv_ms.size()) ? iv_ms[i] : -1, (i < iv_fl.size()) ? iv_fl[i] : 3'bxxx);
      else pass_cnt++;
    end
    total_cnt++;
    if (sm_avg.size() != 1 || sm_avg[0] != 800 || sm_irr[0] != 0 || sm_ver[0] != 0)
      $display("FAIL steady_summary got n=%0d avg=%0d irr=%0d verdict=%0d want n=1 avg=800 irr=0 verdict=0",
               sm_avg.size(), (sm_avg.size() > 0) ? sm_avg[0] : -1, (sm_irr.size() > 0) ? sm_irr[0] : -1,
               (sm_ver.size() > 0) ? sm_ver[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    wait_ms(780);
    beat_then_wait(800);
    beat_then_wait(20);
    total_cnt++;
    if (iv_ms.size() != 2 || iv_ms[0] != 800 || iv_ms[1] != 800)
      $display("FAIL midwin_intervals got n=%0d want two of 800", iv_ms.size()); else pass_cnt++;
    total_cnt++; if (avg_ms !== 16'd800) $display("FAIL summary_hold got %0d want 800", avg_ms); else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (interval_ms !== '0) $display("FAIL midreset_interval got %0d want 0", interval_ms); else pass_cnt++;
    total_cnt++; if ({avg_ms, irr_count, verdict} !== '0)
      $display("FAIL midreset_summary got avg=%0d irr=%0d verdict=%0d want 0", avg_ms, irr_count, verdict); else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat_then_wait(20);
    total_cnt++; if (iv_ms.size() != 2) $display("FAIL post_reset_first_beat got %0d intervals want 2", iv_ms.size()); else pass_cnt++;
    total_cnt++; if (sm_avg.size() != 0) $display("FAIL partial_window_summary got %0d want 0", sm_avg.size()); else pass_cnt++;
  endtask

  task automatic test_brady_tachy();
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) beat_then_wait(1200);
    beat_then_wait(20);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= iv_ms.size() || iv_ms[i] != 1200 || iv_fl[i] !== 3'b100)
        $display("FAIL brady_interval[%0d] got %0d flags %b want 1200 flags 100", i,
                 (i < iv_ms.size()) ? iv_ms[i] : -1, (i < iv_fl.size()) ? iv_fl[i] : 3'bxxx);
      else pass_cnt++;
    end
    total_cnt++;
    if (sm_avg.size() != 1 || sm_avg[0] != 1200 || sm_irr[0] != 0 || sm_ver[0] != 1)
      $display("FAIL brady_summary got n=%0d avg=%0d verdict=%0d want n=1 avg=1200 verdict=1", sm_avg.size(),
               (sm_avg.size() > 0) ? sm_avg[0] : -1, (sm_ver.size() > 0) ? sm_ver[0] : -1);
    else pass_cnt++;

    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) beat_then_wait(500);
    beat_then_wait(20);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (i >= iv_ms.size() || iv_ms[i] != 500 || iv_fl[i] !== 3'b010)
        $display("FAIL tachy_interval[%0d] got %0d flags %b want 500 flags 010", i,
                 (i < iv_ms.size()) ? iv_ms[i] : -1, (i < iv_fl.size()) ? iv_fl[i] : 3'bxxx);
      else pass_cnt++;
    end
    total_cnt++;
    if (sm_avg.size() != 1 || sm_avg[0] != 500 || sm_irr[0] != 0 || sm_ver[0] != 2)
      $display("FAIL tachy_summary got n=%0d avg=%0d verdict=%0d want n=1 avg=500 verdict=2", sm_avg.size(),
               (sm_avg.size() > 0) ? sm_avg[0] : -1, (sm_ver.size() > 0) ? sm_ver[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_irregular();
    int exp_ms;
    logic [2:0] exp_fl;
    do_reset();
    clear_logs();
    for (int i = 0; i < 8; i++) beat_then_wait((i % 2 == 0) ? 800 : 600);
    beat_then_wait(20);
    for (int i = 0; i < 8; i++) begin
      exp_ms = (i % 2 == 0) ? 800 : 600;
      exp_fl = (i == 0) ? 3'b000 : 3'b001;
      total_cnt++;
      if (i >= iv_ms.size() || iv_ms[i] != exp_ms || iv_fl[i] !== exp_fl)
        $display("FAIL irreg_interval[%0d] got %0d flags %b want %0d flags %b", i,
                 (i < iv_ms.size()) ? iv_ms[i] : -1, (i < iv_fl.size()) ? iv_fl[i] : 3'bxxx, exp_ms, exp_fl);
      else pass_cnt++;
    end
    total_cnt++;
    if (sm_avg.size() != 1 || sm_avg[0] != 700 || sm_irr[0] != 7 || sm_ver[0] != 3)
      $display("FAIL irreg_summary got n=%0d avg=%0d irr=%0d verdict=%0d want n=1 avg=700 irr=7 verdict=3",
               sm_avg.size(), (sm_avg.size() > 0) ? sm_avg[0] : -1, (sm_irr.size() > 0) ? sm_irr[0] : -1,
               (sm_ver.size() > 0) ? sm_ver[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_refractory();
    do_reset();
    clear_logs();
    beat_then_wait(150);
    beat_then_wait(650);
    total_cnt++; if (iv_ms.size() != 0) $display("FAIL refractory_drop got %0d intervals want 0", iv_ms.size()); else pass_cnt++;
    beat_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (interval_valid !== 1'b0) $display("FAIL latency_early got %b want 0", interval_valid); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (interval_valid !== 1'b1) $display("FAIL latency_strobe got %b want 1", interval_valid); else pass_cnt++;
    total_cnt++; if (interval_ms !== 16'd800) $display("FAIL refractory_interval got %0d want 800", interval_ms); else pass_cnt++;
    @(posedge clk);
    #1 beat_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++; if (iv_ms.size() != 1) $display("FAIL refractory_count got %0d want 1", iv_ms.size()); else pass_cnt++;
  endtask

  task automatic test_asystole();
    do_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) beat_then_wait(800);
    beat_then_wait(2100);
    total_cnt++; if (iv_ms.size() != 3) $display("FAIL asys_intervals got %0d want 3", iv_ms.size()); else pass_cnt++;
    total_cnt++; if (asystole !== 1'b1) $display("FAIL asys_flag got %b want 1", asystole); else pass_cnt++;
    total_cnt++; if (asys_rise - last_rise != 4 + 2000 * TD)
      $display("FAIL asys_timing got %0d cycles want %0d", asys_rise - last_rise, 4 + 2000 * TD); else pass_cnt++;
    total_cnt++;
    if (sm_avg.size() != 1 || sm_avg[0] != 0 || sm_irr[0] != 0 || sm_ver[0] != 4)
      $display("FAIL asys_summary got n=%0d avg=%0d irr=%0d verdict=%0d want n=1 avg=0 irr=0 verdict=4",
               sm_avg.size(), (sm_avg.size() > 0) ? sm_avg[0] : -1, (sm_irr.size() > 0) ? sm_irr[0] : -1,
               (sm_ver.size() > 0) ? sm_ver[0] : -1);
    else pass_cnt++;
    clear_logs();
    beat_then_wait(800);
    total_cnt++; if (asystole !== 1'b0) $display("FAIL asys_clear got %b want 0", asystole); else pass_cnt++;
    total_cnt++; if (iv_ms.size() != 0) $display("FAIL asys_first_beat got %0d intervals want 0", iv_ms.size()); else pass_cnt++;
    beat_then_wait(20);
    total_cnt++;
    if (iv_ms.size() != 1 || iv_ms[0] != 800 || iv_fl[0] !== 3'b000)
      $display("FAIL asys_recovery got n=%0d ms=%0d want n=1 ms=800 flags 000", iv_ms.size(),
               (iv_ms.size() > 0) ? iv_ms[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    do_reset();
    clear_logs();
    beat_then_wait(400);
    en = 1'b0;
    beat_then_wait(250);
    beat_then_wait(250);
    en = 1'b1;
    total_cnt++; if (iv_ms.size() != 0) $display("FAIL disabled_beat got %0d intervals want 0", iv_ms.size()); else pass_cnt++;
    wait_ms(400);
    beat_then_wait(20);
    total_cnt++;
    if (iv_ms.size() != 1 || iv_ms[0] != 800)
      $display("FAIL enable_freeze got n=%0d ms=%0d want n=1 ms=800", iv_ms.size(), (iv_ms.size() > 0) ? iv_ms[0] : -1);
    else pass_cnt++;
    total_cnt++; if (asystole !== 1'b0) $display("FAIL enable_asys got %b want 0", asystole); else pass_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d cycles", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_steady();
    test_reset_mid();
    test_brady_tachy();
    test_irregular();
    test_refractory();
    test_asystole();
    test_enable();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
